// File: rtl/kernel_cc_fifo_pkg.sv
// Shared constants and elaboration helpers for the kernel_cc shift-register FIFO family.
package kernel_cc_fifo_pkg;

  // Ceiling log2; returns the index width needed to address n entries.
  function automatic int unsigned fifo_clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Occupancy needs one more bit than the index so that DEPTH itself is representable.
  function automatic int unsigned fifo_count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit fifo_params_ok(input int unsigned depth,
                                        input int unsigned addr_width,
                                        input int unsigned af_margin,
                                        input int unsigned ae_margin);
    return (depth >= 2) && (af_margin < depth) && (ae_margin < depth) &&
           ((64'd1 << addr_width) >= 64'(depth));
  endfunction

endpackage

// File: rtl/kernel_cc_fifo_srl_store.sv
// Reset-less shift-register storage: a write shifts every entry up and loads index 0.
module kernel_cc_fifo_srl_store #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] srl [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      srl[0] <= data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        srl[i] <= srl[i-1];
      end
    end
  end

  assign q = srl[a];

endmodule

// File: rtl/kernel_cc_fifo_srl_mon.sv
// HLS channel FIFO with occupancy, almost flags, sticky overflow/underflow and peak watermark.
module kernel_cc_fifo_srl_mon
  import kernel_cc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = fifo_clog2(DEPTH),
  parameter int unsigned AF_MARGIN  = 1,
  parameter int unsigned AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_count,
  output logic                  if_almost_full_n,
  output logic                  if_almost_empty_n,
  input  logic                  err_clr,
  output logic                  if_overflow,
  output logic                  if_underflow,
  output logic [ADDR_WIDTH:0]   if_peak
);

  localparam int unsigned CW = fifo_count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_MARGIN);

  if (!fifo_params_ok(DEPTH, ADDR_WIDTH, AF_MARGIN, AE_MARGIN)) begin : g_bad_params
    $error("kernel_cc_fifo_srl_mon: illegal DEPTH/ADDR_WIDTH/margin combination");
  end

  logic [CW-1:0]         count, count_next;
  logic [CW-1:0]         peak, peak_next;
  logic                  full_n, empty_n, af_n, ae_n, ovf, udf;
  logic                  full_n_next, empty_n_next, af_n_next, ae_n_next;
  logic                  ovf_next, udf_next;
  logic                  wr, rd;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign wr = if_write & if_write_ce & full_n;
  assign rd = if_read  & if_read_ce  & empty_n;

  // Oldest entry sits at index count-1 since writes push everything upward.
  assign rd_addr = (count != '0) ? ADDR_WIDTH'(count - CW'(1)) : '0;

  kernel_cc_fifo_srl_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_store (
    .clk  (clk),
    .ce   (wr & ~reset),
    .data (if_din),
    .a    (rd_addr),
    .q    (if_dout)
  );

  // Next occupancy, status flags, sticky errors and watermark.
  always_comb begin
    count_next = count;
    if (wr && !rd) begin
      count_next = count + CW'(1);
    end else if (rd && !wr) begin
      count_next = count - CW'(1);
    end
    empty_n_next = (count_next != '0);
    full_n_next  = (count_next != FULL_LEVEL);
    af_n_next    = !(count_next >= AF_LEVEL);
    ae_n_next    = !(count_next <= AE_LEVEL);
    ovf_next     = (if_write & if_write_ce & ~full_n)  | (ovf & ~err_clr);
    udf_next     = (if_read  & if_read_ce  & ~empty_n) | (udf & ~err_clr);
    peak_next    = (count_next > peak) ? count_next : peak;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      empty_n <= 1'b0;
      full_n  <= 1'b1;
      af_n    <= 1'b1;
      ae_n    <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      peak    <= '0;
    end else begin
      count   <= count_next;
      empty_n <= empty_n_next;
      full_n  <= full_n_next;
      af_n    <= af_n_next;
      ae_n    <= ae_n_next;
      ovf     <= ovf_next;
      udf     <= udf_next;
      peak    <= peak_next;
    end
  end

  assign if_count          = count;
  assign if_empty_n        = empty_n;
  assign if_full_n         = full_n;
  assign if_almost_full_n  = af_n;
  assign if_almost_empty_n = ae_n;
  assign if_overflow       = ovf;
  assign if_underflow      = udf;
  assign if_peak           = peak;

endmodule

// File: tb/tb_kernel_cc_fifo_srl_mon.sv
// Self-checking bench: directed vector table, a short hand sequence, then random traffic vs a queue model.
module tb_kernel_cc_fifo_srl_mon;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned AF    = 1;
  localparam int unsigned AE    = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] if_din;
  logic          if_write, if_write_ce;
  logic          if_full_n;
  logic [DW-1:0] if_dout;
  logic          if_read, if_read_ce;
  logic          if_empty_n;
  logic [AW:0]   if_count;
  logic          if_almost_full_n, if_almost_empty_n;
  logic          err_clr;
  logic          if_overflow, if_underflow;
  logic [AW:0]   if_peak;

  kernel_cc_fifo_srl_mon #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_MARGIN  (AF),
    .AE_MARGIN  (AE)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .if_din            (if_din),
    .if_write          (if_write),
    .if_write_ce       (if_write_ce),
    .if_full_n         (if_full_n),
    .if_dout           (if_dout),
    .if_read           (if_read),
    .if_read_ce        (if_read_ce),
    .if_empty_n        (if_empty_n),
    .if_count          (if_count),
    .if_almost_full_n  (if_almost_full_n),
    .if_almost_empty_n (if_almost_empty_n),
    .err_clr           (err_clr),
    .if_overflow       (if_overflow),
    .if_underflow      (if_underflow),
    .if_peak           (if_peak)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit       rst, wr, wce;
    bit [7:0] din;
    bit       rd, rce, clr;
    int       cnt;
    bit [7:0] dout;
    bit       dv;
    bit       ovf, udf;
    int       peak;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit wr, bit wce, bit [7:0] din, bit rd, bit rce, bit clr,
                              int cnt, bit [7:0] dout, bit dv, bit ovf, bit udf, int peak);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wce = wce; v.din = din; v.rd = rd; v.rce = rce; v.clr = clr;
    v.cnt = cnt; v.dout = dout; v.dv = dv; v.ovf = ovf; v.udf = udf; v.peak = peak;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flags are derived here from the expected occupancy using the documented thresholds.
  task automatic check_state(input string tag, input int cnt, input bit [7:0] dout, input bit dv,
                             input bit ovf, input bit udf, input int peak);
    chk({tag, ".count"},    32'(if_count),          32'(cnt));
    chk({tag, ".empty_n"},  32'(if_empty_n),        32'(cnt != 0));
    chk({tag, ".full_n"},   32'(if_full_n),         32'(cnt != int'(DEPTH)));
    chk({tag, ".af_n"},     32'(if_almost_full_n),  32'(!(cnt >= int'(DEPTH - AF))));
    chk({tag, ".ae_n"},     32'(if_almost_empty_n), 32'(!(cnt <= int'(AE))));
    chk({tag, ".overflow"}, 32'(if_overflow),       32'(ovf));
    chk({tag, ".underflow"},32'(if_underflow),      32'(udf));
    chk({tag, ".peak"},     32'(if_peak),           32'(peak));
    if (dv) chk({tag, ".dout"}, 32'(if_dout), 32'(dout));
  endtask

  task automatic drive(input bit r, input bit w, input bit we, input bit [7:0] d,
                       input bit rdq, input bit rc, input bit c);
    reset = r; if_write = w; if_write_ce = we; if_din = d;
    if_read = rdq; if_read_ce = rc; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: a queue holding entries oldest-first.
  bit [7:0] mq[$];
  bit       m_ovf, m_udf;
  int       m_peak;

  task automatic rand_step(input int pw, input int pr, input int idx);
    bit r, w, we, rq, rc, c, full, empty, acc_w, acc_r;
    bit [7:0] d;
    r  = ($urandom_range(0, 199) == 0);
    w  = ($urandom_range(0, 99) < pw);
    we = ($urandom_range(0, 7) != 0);
    rq = ($urandom_range(0, 99) < pr);
    rc = ($urandom_range(0, 7) != 0);
    c  = ($urandom_range(0, 15) == 0);
    d  = 8'($urandom);
    if (r) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_peak = 0;
    end else begin
      full  = (mq.size() == int'(DEPTH));
      empty = (mq.size() == 0);
      acc_w = w && we && !full;
      acc_r = rq && rc && !empty;
      m_ovf = (w && we && full)  || (m_ovf && !c);
      m_udf = (rq && rc && empty) || (m_udf && !c);
      if (acc_r) void'(mq.pop_front());
      if (acc_w) mq.push_back(d);
      if (mq.size() > m_peak) m_peak = mq.size();
    end
    drive(r, w, we, d, rq, rc, c);
    check_state($sformatf("rnd%0d", idx), mq.size(), (mq.size() > 0) ? mq[0] : 8'h00,
                mq.size() > 0, m_ovf, m_udf, m_peak);
  endtask

  initial begin
    reset = 1'b1; if_write = 0; if_write_ce = 0; if_din = '0;
    if_read = 0; if_read_ce = 0; err_clr = 0;

    //          rst wr wce din    rd rce clr  cnt dout  dv ovf udf peak
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h11, 0, 0, 0,  1, 8'h11, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h22, 0, 0, 0,  2, 8'h11, 1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 8'h33, 0, 0, 0,  3, 8'h11, 1, 0, 0, 3));
    vecs.push_back(mk(0, 1, 1, 8'h44, 0, 0, 0,  4, 8'h11, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,  3, 8'h22, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,  2, 8'h33, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,  1, 8'h44, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,  0, 8'h00, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'hA1, 0, 0, 0,  1, 8'hA1, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'hA2, 0, 0, 0,  2, 8'hA1, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'hA3, 1, 1, 0,  2, 8'hA2, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,  1, 8'hA3, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,  0, 8'h00, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'h01, 0, 0, 0,  1, 8'h01, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'h02, 0, 0, 0,  2, 8'h01, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'h03, 0, 0, 0,  3, 8'h01, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'h04, 0, 0, 0,  4, 8'h01, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'h55, 1, 1, 0,  3, 8'h02, 1, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,  2, 8'h03, 1, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,  1, 8'h04, 1, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,  0, 8'h00, 0, 1, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'h66, 1, 1, 0,  1, 8'h66, 1, 1, 1, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1,  1, 8'h66, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'h77, 0, 0, 0,  2, 8'h66, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'h88, 0, 0, 0,  3, 8'h66, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'h99, 0, 0, 0,  4, 8'h66, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'hAA, 0, 0, 0,  4, 8'h66, 1, 1, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'hBB, 0, 0, 1,  4, 8'h66, 1, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1,  4, 8'h66, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 8'hCC, 1, 1, 0,  3, 8'h77, 1, 1, 0, 4));
    vecs.push_back(mk(1, 1, 1, 8'hDD, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'hEE, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].wce, vecs[i].din, vecs[i].rd, vecs[i].rce, vecs[i].clr);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].dv,
                  vecs[i].ovf, vecs[i].udf, vecs[i].peak);
    end

    // Read clock-enable gating: requests without ce must neither pop nor flag underflow.
    drive(0, 1, 1, 8'h5A, 0, 0, 0);
    check_state("hand.wr", 1, 8'h5A, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 8'h00, 1, 0, 0);
      check_state($sformatf("hand.rce0_%0d", k), 1, 8'h5A, 1, 0, 0, 1);
    end
    drive(0, 0, 0, 8'h00, 1, 1, 0);
    check_state("hand.rd", 0, 8'h00, 0, 0, 0, 1);
    drive(0, 0, 0, 8'h00, 1, 0, 0);
    check_state("hand.empty_rce0", 0, 8'h00, 0, 0, 0, 1);
    drive(0, 0, 0, 8'h00, 1, 1, 0);
    check_state("hand.empty_rd", 0, 8'h00, 0, 0, 1, 1);

    // Random traffic in phases that bias toward filling, draining and mixed load.
    mq.delete(); m_ovf = 0; m_udf = 0; m_peak = 0;
    drive(1, 0, 0, 8'h00, 0, 0, 0);
    check_state("rnd.reset", 0, 8'h00, 0, 0, 0, 0);
    for (int p = 0; p < 6; p++) begin
      for (int s = 0; s < 150; s++) begin
        case (p % 3)
          0:       rand_step(85, 25, p * 150 + s);
          1:       rand_step(25, 85, p * 150 + s);
          default: rand_step(60, 60, p * 150 + s);
        endcase
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
